alu_datapath: RTL and testbench

- Register-file plus ALU datapath driven cycle-by-cycle by the microprocessor FSM control word (clr, ce, w, sel, s).
- Holds general registers R0–R2 and accumulator A.
- Loads R0–R2 from external inputs M[2:0] or from A.
- Executes one ALU operation per cycle into A and keeps registered carry and zero status for the controller and bench.

---
 rtl/alu_datapath.sv | 135 +++++++++++++
 tb/tb_alu_datapath.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// Register file (R0-R2) plus accumulator/ALU datapath driven by a per-cycle control word.
// Optional signed-overflow flag enabled by defining ALU_DATAPATH_OVF_EN.
module alu_datapath #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [3:0]       ce_i,
  input  logic [2:0]       w_i,
  input  logic [1:0]       sel_i,
  input  logic [2:0]       s_i,
  input  logic [WIDTH-1:0] m0_i,
  input  logic [WIDTH-1:0] m1_i,
  input  logic [WIDTH-1:0] m2_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] r0_o,
  output logic [WIDTH-1:0] r1_o,
  output logic [WIDTH-1:0] r2_o,
  output logic [WIDTH-1:0] a_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] r_r0, r_r1, r_r2, r_a;
  logic             r_cout, r_zero;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;

  always_comb begin
    w_b = r_a;
    unique case (sel_i)
      2'b00:   w_b = r_r0;
      2'b01:   w_b = r_r1;
      2'b10:   w_b = r_r2;
      default: w_b = r_a;
    endcase
  end

  // Every op goes through a WIDTH+1 bit sum so carry is always bit WIDTH.
  always_comb begin
    w_sum = '0;
    unique case (s_i)
      3'b000:  w_sum = {1'b0, r_a} + {1'b0, w_b} + (WIDTH+1)'(cin_i);
      3'b001:  w_sum = {1'b0, r_a} + {1'b0, ~w_b} + (WIDTH+1)'(cin_i);
      3'b010:  w_sum = {1'b0, w_b};
      3'b011:  w_sum = {1'b0, r_a & w_b};
      3'b100:  w_sum = {1'b0, r_a | w_b};
      3'b101:  w_sum = {1'b0, r_a ^ w_b};
      3'b110:  w_sum = {1'b0, r_a} + (WIDTH+1)'(1);
      default: w_sum = {1'b0, r_a};
    endcase
    w_res  = w_sum[WIDTH-1:0];
    w_cout = w_sum[WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r0   <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      r_a    <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else if (clr_i) begin
      r_r0   <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      r_a    <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      // Register sources read pre-edge A, so R_k <= A and A <= ALU may share an edge.
      if (ce_i[0]) r_r0 <= w_i[0] ? r_a : m0_i;
      if (ce_i[1]) r_r1 <= w_i[1] ? r_a : m1_i;
      if (ce_i[2]) r_r2 <= w_i[2] ? r_a : m2_i;
      if (ce_i[3]) begin
        r_a    <= w_res;
        r_cout <= w_cout;
        r_zero <= (w_res == '0);
      end
    end
  end

`ifdef ALU_DATAPATH_OVF_EN
  logic             r_ovf;
  logic             w_ovf;
  logic             w_eb_sign;

  always_comb begin
    w_ovf     = 1'b0;
    w_eb_sign = 1'b0;
    unique case (s_i)
      3'b000: begin
        w_eb_sign = w_b[WIDTH-1];
        w_ovf     = (r_a[WIDTH-1] == w_eb_sign) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      3'b001: begin
        w_eb_sign = ~w_b[WIDTH-1];
        w_ovf     = (r_a[WIDTH-1] == w_eb_sign) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      3'b110: begin
        // Increment operand is +1, always non-negative.
        w_eb_sign = 1'b0;
        w_ovf     = (r_a[WIDTH-1] == w_eb_sign) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      default: begin
        w_eb_sign = 1'b0;
        w_ovf     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_ovf <= 1'b0;
    else if (clr_i)    r_ovf <= 1'b0;
    else if (ce_i[3])  r_ovf <= w_ovf;
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = 1'b0;
`endif

  assign r0_o   = r_r0;
  assign r1_o   = r_r1;
  assign r2_o   = r_r2;
  assign a_o    = r_a;
  assign cout_o = r_cout;
  assign zero_o = r_zero;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (WIDTH=4); expects ovf_o per ALU_DATAPATH_OVF_EN.
module tb_alu_datapath;

  localparam int unsigned W = 4;

`ifdef ALU_DATAPATH_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clr_i;
  logic [3:0]   ce_i;
  logic [2:0]   w_i;
  logic [1:0]   sel_i;
  logic [2:0]   s_i;
  logic [W-1:0] m0_i, m1_i, m2_i;
  logic         cin_i;
  logic [W-1:0] r0_o, r1_o, r2_o, a_o;
  logic         cout_o, zero_o, ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_datapath #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clr_i(clr_i), .ce_i(ce_i), .w_i(w_i),
    .sel_i(sel_i), .s_i(s_i), .m0_i(m0_i), .m1_i(m1_i), .m2_i(m2_i),
    .cin_i(cin_i), .r0_o(r0_o), .r1_o(r1_o), .r2_o(r2_o), .a_o(a_o),
    .cout_o(cout_o), .zero_o(zero_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [3:0] ce, input logic [2:0] w,
                     input logic [1:0] sel, input logic [2:0] s, input logic cin);
    ce_i = ce; w_i = w; sel_i = sel; s_i = s; cin_i = cin;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_i = 1'b0; ctl(4'b0000, 3'b000, 2'b00, 3'b000, 1'b0);
    m0_i = '0; m1_i = '0; m2_i = '0;
    #2;
    n_cmp++; if ({r0_o, r1_o, r2_o, a_o} !== 16'h0000) begin n_err++; $display("FAIL reset_regs: got %h expected 0000", {r0_o, r1_o, r2_o, a_o}); end
    n_cmp++; if ({cout_o, zero_o, ovf_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {cout_o, zero_o, ovf_o}); end
    step();
    reset = 1'b0;
    // preload everything nonzero, then assert reset between edges
    m0_i = 4'd6; m1_i = 4'd7; m2_i = 4'd8;
    ctl(4'b0111, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b01, 3'b110, 1'b0); step();
    n_cmp++; if (a_o !== 4'd1) begin n_err++; $display("FAIL preload_a: got %0d expected 1", a_o); end
    ctl(4'b0000, 3'b000, 2'b00, 3'b000, 1'b0);
    #2 reset = 1'b1;
    #2;
    n_cmp++; if ({r0_o, r1_o, r2_o, a_o} !== 16'h0000) begin n_err++; $display("FAIL async_reset_regs: got %h expected 0000", {r0_o, r1_o, r2_o, a_o}); end
    n_cmp++; if ({cout_o, zero_o, ovf_o} !== 3'b000) begin n_err++; $display("FAIL async_reset_flags: got %b expected 000", {cout_o, zero_o, ovf_o}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clear();
    m0_i = 4'd15; m1_i = 4'd1; m2_i = 4'd2;
    ctl(4'b0111, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b110, 1'b0); step(); // A = 0+1
    ctl(4'b1000, 3'b000, 2'b00, 3'b000, 1'b1); step(); // A = 1+15+1 = 17 -> 1, carry
    n_cmp++; if ({a_o, cout_o} !== {4'd1, 1'b1}) begin n_err++; $display("FAIL clear_preload: got a=%0d c=%b expected a=1 c=1", a_o, cout_o); end
    clr_i = 1'b1; ctl(4'b1111, 3'b111, 2'b11, 3'b110, 1'b1); step();
    clr_i = 1'b0;
    n_cmp++; if ({r0_o, r1_o, r2_o, a_o} !== 16'h0000) begin n_err++; $display("FAIL clear_regs: got %h expected 0000", {r0_o, r1_o, r2_o, a_o}); end
    n_cmp++; if ({cout_o, zero_o, ovf_o} !== 3'b000) begin n_err++; $display("FAIL clear_flags: got %b expected 000", {cout_o, zero_o, ovf_o}); end
  endtask

  task automatic test_load();
    m0_i = 4'd5; m1_i = 4'd3; m2_i = 4'd9;
    ctl(4'b0111, 3'b000, 2'b00, 3'b000, 1'b0); step();
    n_cmp++; if ({r0_o, r1_o, r2_o} !== {4'd5, 4'd3, 4'd9}) begin n_err++; $display("FAIL load_regs: got %0d/%0d/%0d expected 5/3/9", r0_o, r1_o, r2_o); end
    n_cmp++; if (a_o !== 4'd0) begin n_err++; $display("FAIL load_a_hold: got %0d expected 0", a_o); end
  endtask

  task automatic test_sub();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step();
    n_cmp++; if ({a_o, cout_o, zero_o} !== {4'd5, 1'b0, 1'b0}) begin n_err++; $display("FAIL passb: got a=%0d c=%b z=%b expected a=5 c=0 z=0", a_o, cout_o, zero_o); end
    ctl(4'b1000, 3'b000, 2'b01, 3'b001, 1'b1); step();
    n_cmp++; if ({a_o, cout_o, zero_o} !== {4'd2, 1'b1, 1'b0}) begin n_err++; $display("FAIL sbc: got a=%0d c=%b z=%b expected a=2 c=1 z=0", a_o, cout_o, zero_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL sbc_ovf: got %b expected 0", ovf_o); end
    ctl(4'b0100, 3'b100, 2'b00, 3'b000, 1'b0); step();
    n_cmp++; if ({r0_o, r1_o, r2_o, a_o} !== {4'd5, 4'd3, 4'd2, 4'd2}) begin n_err++; $display("FAIL r2_from_a: got %0d/%0d/%0d/%0d expected 5/3/2/2", r0_o, r1_o, r2_o, a_o); end
  endtask

  task automatic test_wrap();
    m0_i = 4'd15;
    ctl(4'b0001, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step();
    n_cmp++; if (a_o !== 4'd15) begin n_err++; $display("FAIL wrap_setup: got %0d expected 15", a_o); end
    ctl(4'b1000, 3'b000, 2'b00, 3'b110, 1'b0); step();
    n_cmp++; if ({a_o, cout_o, zero_o} !== {4'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL inc_wrap: got a=%0d c=%b z=%b expected a=0 c=1 z=1", a_o, cout_o, zero_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL inc_wrap_ovf: got %b expected 0", ovf_o); end
    ctl(4'b0000, 3'b111, 2'b01, 3'b110, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({a_o, cout_o, zero_o} !== {4'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL hold_%0d: got a=%0d c=%b z=%b expected a=0 c=1 z=1", i, a_o, cout_o, zero_o); end
    end
  endtask

  task automatic test_same_edge();
    m0_i = 4'd7;
    ctl(4'b0001, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step();
    ctl(4'b1001, 3'b001, 2'b11, 3'b000, 1'b0); step();
    n_cmp++; if ({r0_o, a_o} !== {4'd7, 4'd14}) begin n_err++; $display("FAIL same_edge: got r0=%0d a=%0d expected r0=7 a=14", r0_o, a_o); end
    n_cmp++; if ({cout_o, zero_o, ovf_o} !== {1'b0, 1'b0, OVF_ON}) begin n_err++; $display("FAIL same_edge_flags: got %b expected %b", {cout_o, zero_o, ovf_o}, {1'b0, 1'b0, OVF_ON}); end
  endtask

  task automatic test_ovf();
    m0_i = 4'd7; m1_i = 4'd1;
    ctl(4'b0011, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step();
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_after_pass: got %b expected 0", ovf_o); end
    ctl(4'b1000, 3'b000, 2'b01, 3'b000, 1'b0); step();
    n_cmp++; if ({a_o, cout_o, zero_o} !== {4'd8, 1'b0, 1'b0}) begin n_err++; $display("FAIL adc_ovf_res: got a=%0d c=%b z=%b expected a=8 c=0 z=0", a_o, cout_o, zero_o); end
    n_cmp++; if (ovf_o !== OVF_ON) begin n_err++; $display("FAIL adc_ovf: got %b expected %b", ovf_o, OVF_ON); end
    ctl(4'b0000, 3'b000, 2'b01, 3'b011, 1'b0); step();
    n_cmp++; if (ovf_o !== OVF_ON) begin n_err++; $display("FAIL ovf_hold: got %b expected %b", ovf_o, OVF_ON); end
    ctl(4'b1000, 3'b000, 2'b01, 3'b011, 1'b0); step(); // 8 & 1 = 0
    n_cmp++; if ({a_o, zero_o, ovf_o} !== {4'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL and_flags: got a=%0d z=%b v=%b expected a=0 z=1 v=0", a_o, zero_o, ovf_o); end
    // SBC overflow: A=8 (-8) minus R1=1 -> 7
    m0_i = 4'd8;
    ctl(4'b0001, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b01, 3'b001, 1'b1); step();
    n_cmp++; if ({a_o, cout_o, ovf_o} !== {4'd7, 1'b1, OVF_ON}) begin n_err++; $display("FAIL sbc_ovf_case: got a=%0d c=%b v=%b expected a=7 c=1 v=%b", a_o, cout_o, ovf_o, OVF_ON); end
  endtask

  task automatic test_logic_ops();
    // A=7, R1=1 from previous loads via M
    m0_i = 4'd12; m1_i = 4'd10;
    ctl(4'b0011, 3'b000, 2'b00, 3'b000, 1'b0); step();
    ctl(4'b1000, 3'b000, 2'b00, 3'b010, 1'b0); step(); // A=12
    ctl(4'b1000, 3'b000, 2'b01, 3'b100, 1'b1); step(); // 12|10=14
    n_cmp++; if ({a_o, cout_o} !== {4'd14, 1'b0}) begin n_err++; $display("FAIL or_op: got a=%0d c=%b expected a=14 c=0", a_o, cout_o); end
    ctl(4'b1000, 3'b000, 2'b01, 3'b101, 1'b1); step(); // 14^10=4
    n_cmp++; if ({a_o, cout_o} !== {4'd4, 1'b0}) begin n_err++; $display("FAIL xor_op: got a=%0d c=%b expected a=4 c=0", a_o, cout_o); end
    ctl(4'b1000, 3'b000, 2'b00, 3'b111, 1'b1); step();
    n_cmp++; if ({a_o, zero_o} !== {4'd4, 1'b0}) begin n_err++; $display("FAIL passa_op: got a=%0d z=%b expected a=4 z=0", a_o, zero_o); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load();
    test_sub();
    test_wrap();
    test_same_edge();
    test_ovf();
    test_logic_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
